// File: rtl/serial_add_pkg.sv
// Shared types and constants for the 2-bit-digit serial adder.
package serial_add_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Handshake/operand bundle for serial_add_ctrl.
// Carries the optional sub request when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_add2_slice.sv
// Combinational 2-bit adder with carry-in/carry-out; the only arithmetic in the datapath.
module add2_slice
  import serial_add_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, ci};

endmodule

// File: rtl/serial_add_ctrl.sv
// Digit-serial adder: one 2-bit digit per RUN cycle, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub (a - b) mode.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = $clog2(N);
  localparam logic [WIDTH-1:0] DIG_MASK = {{(WIDTH-DIGIT_W){1'b0}}, {DIGIT_W{1'b1}}};

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("serial_add_ctrl: WIDTH must be even and >= 4");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d;

  logic [CNT_W:0]     shamt;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [DIGIT_W-1:0] a_dig, b_dig, s_dig;
  logic               c_out;
  logic               accept;

  assign shamt  = {cnt_q, 1'b0};
  assign a_sh   = a_q >> shamt;
  assign b_sh   = b_q >> shamt;
  assign a_dig  = a_sh[DIGIT_W-1:0];
  assign b_dig  = b_sh[DIGIT_W-1:0];
  assign accept = bus.start && (state_q != RUN);

  add2_slice u_slice (
    .x  (a_dig),
    .y  (b_dig),
    .ci (carry_q),
    .s  (s_dig),
    .co (c_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (accept) begin
      a_d     = bus.a;
      cnt_d   = '0;
      sum_d   = '0;
      state_d = RUN;
`ifdef SERIAL_ADD_SUB_EN
      // Subtract as a + ~b + 1; cout then reads as "no borrow".
      b_d     = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub ? 1'b1 : bus.cin;
`else
      b_d     = bus.b;
      carry_d = bus.cin;
`endif
    end else if (state_q == RUN) begin
      sum_d   = (sum_q & ~(DIG_MASK << shamt))
              | ({{(WIDTH-DIGIT_W){1'b0}}, s_dig} << shamt);
      carry_d = c_out;
      if (cnt_q == CNT_W'(N - 1)) begin
        state_d = DONE;
        cout_d  = c_out;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Operand registers only change on an accepted start, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
- REQ-001 Parameter WIDTH, default 8: operand width in bits. SHALL be even and >= 4; other values are an elaboration error.
- REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-003 Port rst, input, 1: reset, synchronous and active-high.
- REQ-004 Port start, input, 1: request an operation; sampled each rising edge.
- REQ-005 Port a, input, WIDTH: operand A; captured on an accepted start.
- REQ-006 Port b, input, WIDTH: operand B; captured on an accepted start.
- REQ-007 Port cin, input, 1: carry-in; captured on an accepted start.
- REQ-008 Port busy, output, 1: high while the operation is in progress.
- REQ-009 Port done, output, 1: one-cycle pulse when the result is valid.
- REQ-010 Port sum, output, WIDTH: result; held until the next accepted start.
- REQ-011 Port cout, output, 1: final carry-out; held with sum.

Function
- REQ-012 FSM SHALL have exactly three states:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasting one cycle.
- REQ-013 Start acceptance: start=1 in IDLE or DONE SHALL be accepted, and SHALL:
  - latch a, b and cin;
  - clear the digit counter;
  - clear sum to 0;
  - move to RUN.
- REQ-014 start=1 in RUN SHALL be ignored; operand registers SHALL remain unchanged.
- REQ-015 Digit processing: each RUN cycle SHALL process one 2-bit digit, LSB first, with N = WIDTH/2 digits. Digit k (bits 2k+1:2k) SHALL be added to the carry register. The 2-bit sum SHALL be written into the same bits of sum. The carry-out SHALL replace the carry register.
- REQ-016 Exit from RUN: after digit N-1 the FSM SHALL enter DONE, and cout SHALL equal the final carry.
- REQ-017 Latency: with start accepted at edge E, done SHALL be high in the cycle following edge E+N, for exactly one cycle.
- REQ-018 DONE SHALL return to IDLE on the next edge, unless start=1, in which case it SHALL enter RUN directly (back-to-back operation).
- REQ-019 Result hold: sum and cout SHALL hold their values outside RUN. The one exception is the sum clear on an accepted start (REQ-013).
- REQ-020 Arithmetic: the result SHALL equal {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), exactly.

Reset
- REQ-021 rst=1 SHALL force, at the next edge:
  - FSM state to IDLE;
  - busy=0, done=0;
  - sum=0, cout=0;
  - digit counter and carry register to 0.
- REQ-022 Reset SHALL take priority over start.
- REQ-023 Reset during RUN SHALL abort the operation with no done pulse.

Configuration
- REQ-024 Macro SERIAL_ADD_SUB_EN defined:
  - an extra port sub (input, 1) SHALL exist, captured on an accepted start;
  - when sub=1: b SHALL be inverted, the initial carry SHALL be 1, cin SHALL be ignored, and cout=1 SHALL mean no borrow, i.e. sum = a - b mod 2^WIDTH.
- REQ-025 Macro SERIAL_ADD_SUB_EN undefined: the sub port SHALL be absent, and behaviour SHALL be add-only per REQ-020.

Structure
- REQ-026 Package serial_add_pkg SHALL hold:
  - the state enum (IDLE, RUN, DONE);
  - constant DIGIT_W = 2.
- REQ-027 Sub-module add2_slice SHALL be the only arithmetic: a combinational 2-bit add with carry-in and carry-out, instantiated once.
- REQ-028 The counter SHALL be $clog2(WIDTH/2) bits wide.

Verification (WIDTH=8 unless stated)
- REQ-029 a=0x3C, b=0x15, cin=0, start for one cycle -> busy high for 4 cycles, done at E+4, sum=0x51, cout=0.
- REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- REQ-031 start held high through RUN with changing a and b -> result from the first-captured operands only. Second op accepted in the DONE cycle -> second done exactly 5 edges after the first.
- REQ-032 rst asserted at the 2nd RUN cycle -> next cycle busy=0, sum=0, cout=0, and no done pulse.
- REQ-033 SERIAL_ADD_SUB_EN, sub=1:
  - a=0x10, b=0x01 -> sum=0x0F, cout=1;
  - a=0x01, b=0x02 -> sum=0xFF, cout=0.
- REQ-034 WIDTH=16, 1000 random operand and cin sets -> every result matches a+b+cin, with done latency 8.
